// File: rtl/retire_sync.sv
// retire_sync -- lockstep retire aligner for NUM_CH redundant core copies.
//
// Each core copy is gated by its en_o bit. When a copy retires an instruction
// its enable drops and it waits until every peer has retired too. Then a
// one-cycle ALIGN pulse (retire_o) is issued, the aligned-retire counter
// advances, and all copies are released together. If one copy waits
// MAX_STALL cycles for its peers, the block latches HALT (desync_o) until
// reset.
//
// Optional feature macro: RETIRE_SYNC_SKEW_EN -- when defined, max_skew_o
// tracks the largest wait seen at ALIGN/HALT entry; otherwise it is tied to 0.
//
// Ports:
//   clk_i         rising-edge system clock
//   rst_ni        asynchronous active-low reset
//   retire_i      per-channel retire strobe (ignored while en_o bit is 0)
//   en_o          per-channel clock-enable for the core copies
//   retire_o      one-cycle pulse per aligned retire
//   retire_cnt_o  aligned-retire count, wraps modulo 2^CNT_W
//   desync_o      sticky stall-timeout flag
//   max_skew_o    largest observed wait in cycles (0 without the macro)
module retire_sync #(
    parameter int NUM_CH    = 2,
    parameter int MAX_STALL = 15,
    parameter int CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] retire_i,
    output logic [NUM_CH-1:0] en_o,
    output logic              retire_o,
    output logic [CNT_W-1:0]  retire_cnt_o,
    output logic              desync_o,
    output logic [7:0]        max_skew_o
);

    typedef enum logic [1:0] {RUN, ALIGN, HALT} state_t;

    localparam logic [7:0] MAX_STALL_B = 8'(MAX_STALL);

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] held_q, held_d;
    logic [7:0]        stall_q, stall_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] hit;
    logic [7:0]        stall_inc;

    // A channel can only retire while enabled, i.e. while not already held.
    assign hit       = held_q | (retire_i & ~held_q);
    assign stall_inc = stall_q + 8'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            held_q  <= '0;
            stall_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            stall_q <= stall_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        held_d   = held_q;
        stall_d  = stall_q;
        cnt_d    = cnt_q;
        en_o     = '0;
        retire_o = 1'b0;
        case (state_q)
            RUN: begin
                en_o   = ~held_q;
                held_d = hit;
                if (&hit) begin
                    // Alignment takes priority over a timeout on the same edge.
                    state_d = ALIGN;
                    stall_d = '0;
                end else if (held_q == '0) begin
                    stall_d = '0;
                end else if (stall_inc == MAX_STALL_B) begin
                    state_d = HALT;
                    stall_d = stall_inc;
                end else begin
                    stall_d = stall_inc;
                end
            end
            ALIGN: begin
                retire_o = 1'b1;
                held_d   = '0;
                stall_d  = '0;
                cnt_d    = cnt_q + CNT_W'(1);
                state_d  = RUN;
            end
            default: ; // HALT: everything gated until reset
        endcase
    end

    assign retire_cnt_o = cnt_q;
    assign desync_o     = (state_q == HALT);

`ifdef RETIRE_SYNC_SKEW_EN
    // Skew sample is the wait length including the edge that ends it; an
    // alignment with nobody waiting contributes 0.
    logic [7:0] skew_q;
    logic [7:0] skew_cand;
    logic       skew_upd;

    always_comb begin
        skew_upd  = 1'b0;
        skew_cand = '0;
        if (state_q == RUN && state_d != RUN) begin
            skew_upd  = 1'b1;
            skew_cand = (held_q == '0) ? 8'd0 : stall_inc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            skew_q <= '0;
        else if (skew_upd && skew_cand > skew_q)
            skew_q <= skew_cand;
    end

    assign max_skew_o = skew_q;
`else
    assign max_skew_o = '0;
`endif

endmodule

// File: doc/retire_sync.md
RETIRE_SYNC -- requirements
Module: retire_sync

Interface
REQ-001 Parameter NUM_CH, default 2: number of lockstepped core copies, legal range 2..8.
REQ-002 Parameter MAX_STALL, default 15: maximum cycles one channel waits for its peers before desync is declared, legal range 1..255.
REQ-003 Parameter CNT_W, default 16: width of the aligned-retire counter.
REQ-004 clk_i  input  1: single system clock, rising-edge.
REQ-005 rst_ni  input  1: asynchronous, active-low reset.
REQ-006 retire_i  input  NUM_CH: per-channel retire strobe, meaningful only while that channel's en_o bit is 1.
REQ-007 en_o  output  NUM_CH: per-channel clock-enable for core copy i; 1 lets the copy advance this cycle.
REQ-008 retire_o  output  1: one-cycle pulse when all channels have retired one instruction.
REQ-009 retire_cnt_o  output  CNT_W: count of aligned retires.
REQ-010 desync_o  output  1: sticky flag for a stall timeout.
REQ-011 max_skew_o  output  8: largest wait observed, in cycles (see Configuration).

Function
REQ-012 The FSM SHALL have the states RUN, ALIGN and HALT.
REQ-013 The block SHALL keep a held vector of NUM_CH bits, and en_o SHALL equal ~held in RUN and all-zero in ALIGN and HALT.
REQ-014 In RUN, held[i] SHALL set at the clock edge where retire_i[i]=1 and en_o[i]=1.
REQ-015 retire_i[i] SHALL be ignored while en_o[i]=0.
REQ-016 RUN SHALL go to ALIGN at the edge where (held | (retire_i & en_o)) is all-ones; simultaneous retires on any subset of channels, including all of them at once, count in that same edge.
REQ-017 ALIGN SHALL last exactly one cycle.
REQ-018 During ALIGN, retire_o SHALL be 1 and en_o SHALL be 0.
REQ-019 On leaving ALIGN, the block SHALL clear held, increment retire_cnt_o by 1 (wrapping modulo 2^CNT_W) and return to RUN.
REQ-020 The latency from the last channel's retire edge to retire_o=1 SHALL be one cycle.
REQ-021 A stall counter (8 bits) SHALL increment each RUN cycle where held is non-zero and not all-ones, and SHALL clear whenever held is zero or on entry to ALIGN.
REQ-022 When the stall counter reaches MAX_STALL with alignment not completing on that edge, the FSM SHALL enter HALT.
REQ-023 In HALT, desync_o=1, en_o=0 and retire_o=0, and HALT SHALL be left only by reset.
REQ-024 If alignment completes on the same edge the counter would reach MAX_STALL, alignment SHALL win and the FSM SHALL enter ALIGN.
REQ-025 retire_o SHALL be 0 in RUN and HALT.

Reset
REQ-026 While rst_ni=0, the block SHALL hold: FSM=RUN, held=0, stall counter=0, retire_cnt_o=0, desync_o=0, max_skew_o=0, retire_o=0, en_o=all-ones.
REQ-027 Reset assertion SHALL take effect immediately, independent of clk_i, including mid-ALIGN and in HALT.
REQ-028 Deassertion SHALL be sampled at the next rising edge of clk_i.
REQ-029 Retires arriving in the cycle of deassertion SHALL be processed normally.

Configuration
REQ-030 The macro RETIRE_SYNC_SKEW_EN SHALL select whether skew tracking is compiled in.
REQ-031 With RETIRE_SYNC_SKEW_EN defined, on each entry to ALIGN max_skew_o SHALL update to max(max_skew_o, stall counter value at that edge); it SHALL also update on entry to HALT.
REQ-032 Without RETIRE_SYNC_SKEW_EN, max_skew_o SHALL be constant 0 and no skew register SHALL be synthesised.
REQ-033 All other behaviour SHALL be identical with or without RETIRE_SYNC_SKEW_EN.

Verification
REQ-034 Equal retires (NUM_CH=2): both channels retire on the same edge -> retire_o=1 next cycle with en_o=00; then en_o=11 and retire_cnt_o=1.
REQ-035 Skewed retires (NUM_CH=4): ch0 retires at t=0, ch1..3 at t=3 -> en_o[0]=0 for t=1..3, retire_o at t=4, max_skew_o=3 with RETIRE_SYNC_SKEW_EN defined.
REQ-036 Timeout (MAX_STALL=5): ch1 never retires after ch0 retires -> desync_o=1 at stall count 5, en_o=0 thereafter, and further retires have no effect.
REQ-037 Boundary: the last channel retires on the edge where the counter hits MAX_STALL -> ALIGN is entered and desync_o stays 0.
REQ-038 Wrap (CNT_W=4): 16 aligned retires -> retire_cnt_o returns to 0 with no other side effects.
REQ-039 Async reset asserted mid-ALIGN and in HALT -> all outputs at reset values within the same cycle with no clock edge, and normal operation resumes after deassertion.
